lock_sequencer: RTL and testbench

Controller for the 3-bit keypad-code lock. Accepts code digits over a valid/ready handshake and compares the full sequence against a programmable code register. Drives a timed unlock window, counts failed attempts and enforces a lockout period. Sits between the keypad front end and the door actuator; the code can only be reprogrammed while unlocked.

---
 rtl/lock_sequencer_if.sv | 30 +++
 rtl/lock_sequencer.sv | 176 +++++++++++++++++
 tb/tb_lock_sequencer.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lock_sequencer_if.sv
// Keypad/programming/actuator signal bundle for lock_sequencer.
// master = keypad and host side, slave = sequencer side.
interface lock_sequencer_if #(
  parameter int unsigned DIGIT_W   = 3,
  parameter int unsigned CODE_LEN  = 3,
  parameter int unsigned MAX_FAILS = 3
);
  localparam int unsigned FcW = $clog2(MAX_FAILS + 1);

  logic                         digit_valid;
  logic [DIGIT_W-1:0]           digit;
  logic                         digit_ready;
  logic                         prog_req;
  logic [CODE_LEN*DIGIT_W-1:0]  prog_code;
  logic                         prog_ack;
  logic                         unlock;
  logic                         locked_out;
  logic                         fail_pulse;
  logic [FcW-1:0]               fail_count;

  modport master (
    output digit_valid, digit, prog_req, prog_code,
    input  digit_ready, prog_ack, unlock, locked_out, fail_pulse, fail_count
  );

  modport slave (
    input  digit_valid, digit, prog_req, prog_code,
    output digit_ready, prog_ack, unlock, locked_out, fail_pulse, fail_count
  );
endinterface

// File: rtl/lock_sequencer.sv
// Keypad code lock: digit entry, code compare, timed unlock window, fail counting and lockout.
// Optional inter-digit entry timeout enabled by defining LOCK_SEQ_ENTRY_TIMEOUT_EN.
module lock_sequencer #(
  parameter int unsigned                      DIGIT_W        = 3,
  parameter int unsigned                      CODE_LEN       = 3,
  parameter int unsigned                      MAX_FAILS      = 3,
  parameter int unsigned                      UNLOCK_CYCLES  = 8,
  parameter int unsigned                      LOCKOUT_CYCLES = 16,
  parameter logic [CODE_LEN*DIGIT_W-1:0]      DEFAULT_CODE   = 9'b011_111_101,
  parameter int unsigned                      TIMEOUT_CYCLES = 32
) (
  input logic             clk,
  input logic             reset,
  lock_sequencer_if.slave bus
);

  localparam int unsigned CodeW  = CODE_LEN * DIGIT_W;
  localparam int unsigned IdxW   = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int unsigned FcW    = $clog2(MAX_FAILS + 1);
  localparam int unsigned MaxCyc = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxCyc + 1);
  localparam logic [FcW-1:0] MaxFails = FcW'(MAX_FAILS);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StEntry    = 3'd1;
  localparam logic [2:0] StCheck    = 3'd2;
  localparam logic [2:0] StUnlocked = 3'd3;
  localparam logic [2:0] StLockout  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [CodeW-1:0] digits_q, digits_d;
  logic [CodeW-1:0] code_q, code_d;
  logic [FcW-1:0]   fails_q, fails_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             fail_pulse_q, fail_pulse_d;
  logic             prog_ack_q, prog_ack_d;
  logic             digit_ready;
  logic             accept;
  logic             attempt_fail;
  logic [FcW-1:0]   fails_inc;

`ifdef LOCK_SEQ_ENTRY_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TmoW-1:0] tmo_q, tmo_d;
`else
  // TIMEOUT_CYCLES only matters when the entry timeout is built in
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end
`endif

  assign digit_ready = (state_q == StIdle) || (state_q == StEntry);
  assign accept      = bus.digit_valid && digit_ready;
  assign fails_inc   = (fails_q == MaxFails) ? fails_q : fails_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    digits_d     = digits_q;
    code_d       = code_q;
    fails_d      = fails_q;
    cnt_d        = cnt_q;
    fail_pulse_d = 1'b0;
    prog_ack_d   = 1'b0;
    attempt_fail = 1'b0;
`ifdef LOCK_SEQ_ENTRY_TIMEOUT_EN
    tmo_d        = tmo_q;
`endif

    case (state_q)
      StIdle, StEntry: begin
        if (accept) begin
          // Shift in so the first digit ends up in the MSBs, matching the code register
          digits_d = (digits_q << DIGIT_W) | CodeW'(bus.digit);
`ifdef LOCK_SEQ_ENTRY_TIMEOUT_EN
          tmo_d    = '0;
`endif
          if (idx_q == IdxW'(CODE_LEN - 1)) begin
            state_d = StCheck;
            idx_d   = '0;
          end else begin
            state_d = StEntry;
            idx_d   = idx_q + 1'b1;
          end
        end
`ifdef LOCK_SEQ_ENTRY_TIMEOUT_EN
        else if (state_q == StEntry) begin
          if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
            attempt_fail = 1'b1;
            idx_d        = '0;
            tmo_d        = '0;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
`endif
      end
      StCheck: begin
        if (digits_q == code_q) begin
          state_d = StUnlocked;
          cnt_d   = CntW'(UNLOCK_CYCLES);
          fails_d = '0;
        end else begin
          attempt_fail = 1'b1;
        end
      end
      StUnlocked: begin
        if (bus.prog_req) begin
          code_d     = bus.prog_code;
          prog_ack_d = 1'b1;
          state_d    = StIdle;
        end else if (cnt_q == CntW'(1)) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StLockout: begin
        if (cnt_q == CntW'(1)) begin
          state_d = StIdle;
          fails_d = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (attempt_fail) begin
      fail_pulse_d = 1'b1;
      fails_d      = fails_inc;
      if (fails_inc == MaxFails) begin
        state_d = StLockout;
        cnt_d   = CntW'(LOCKOUT_CYCLES);
      end else begin
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      digits_q     <= '0;
      code_q       <= DEFAULT_CODE;
      fails_q      <= '0;
      cnt_q        <= '0;
      fail_pulse_q <= 1'b0;
      prog_ack_q   <= 1'b0;
`ifdef LOCK_SEQ_ENTRY_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      digits_q     <= digits_d;
      code_q       <= code_d;
      fails_q      <= fails_d;
      cnt_q        <= cnt_d;
      fail_pulse_q <= fail_pulse_d;
      prog_ack_q   <= prog_ack_d;
`ifdef LOCK_SEQ_ENTRY_TIMEOUT_EN
      tmo_q        <= tmo_d;
`endif
    end
  end

  assign bus.digit_ready = digit_ready;
  assign bus.unlock      = (state_q == StUnlocked);
  assign bus.locked_out  = (state_q == StLockout);
  assign bus.fail_pulse  = fail_pulse_q;
  assign bus.prog_ack    = prog_ack_q;
  assign bus.fail_count  = fails_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// Self-checking bench for lock_sequencer: directed scenarios plus randomized attempts
// checked against a transaction-level model of the lock (current code, fail count).
module tb_lock_sequencer;

  localparam int unsigned DIGIT_W        = 3;
  localparam int unsigned CODE_LEN       = 3;
  localparam int unsigned MAX_FAILS      = 3;
  localparam int unsigned UNLOCK_CYCLES  = 8;
  localparam int unsigned LOCKOUT_CYCLES = 16;
  localparam int unsigned TIMEOUT_CYCLES = 32;
  localparam logic [8:0]  DEFAULT_CODE   = 9'b011_111_101;
  localparam logic [8:0]  WRONG_CODE     = 9'b011_000_101;
  localparam logic [8:0]  NEW_CODE       = 9'b001_010_100;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  lock_sequencer_if #(
    .DIGIT_W  (DIGIT_W),
    .CODE_LEN (CODE_LEN),
    .MAX_FAILS(MAX_FAILS)
  ) bus ();

  lock_sequencer #(
    .DIGIT_W       (DIGIT_W),
    .CODE_LEN      (CODE_LEN),
    .MAX_FAILS     (MAX_FAILS),
    .UNLOCK_CYCLES (UNLOCK_CYCLES),
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES),
    .DEFAULT_CODE  (DEFAULT_CODE),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: the code the lock should currently accept and consecutive failures
  logic [8:0] model_code;
  int         model_fails;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Idle cycles between digits; prog_req is toggled randomly and must be ignored
  task automatic idle_gap(input int n);
    repeat (n) begin
      bus.prog_req  = 1'($urandom_range(0, 1));
      bus.prog_code = 9'($urandom);
      step();
      bus.prog_req  = 1'b0;
      check_eq("prog_ack_idle", 32'(bus.prog_ack), 32'd0);
    end
  endtask

  task automatic send_digit(input logic [2:0] d);
    check_eq("digit_ready", 32'(bus.digit_ready), 32'd1);
    bus.digit_valid = 1'b1;
    bus.digit       = d;
    step();
    bus.digit_valid = 1'b0;
    bus.digit       = 3'($urandom);
  endtask

  task automatic send_code(input logic [8:0] c, input int gap_max);
    for (int i = 0; i < 3; i++) begin
      idle_gap($urandom_range(0, gap_max));
      send_digit(c[8-3*i -: 3]);
    end
  endtask

  // Called in the cycle right after the last digit handshake (the compare cycle)
  task automatic check_result(input logic [8:0] c, input int prog_at, input logic [8:0] nc);
    check_eq("check_ready", 32'(bus.digit_ready), 32'd0);
    check_eq("check_unlock", 32'(bus.unlock), 32'd0);
    check_eq("check_fail_pulse", 32'(bus.fail_pulse), 32'd0);
    step();
    if (c == model_code) begin
      model_fails = 0;
      check_eq("fail_count_ok", 32'(bus.fail_count), 32'd0);
      check_eq("fail_pulse_ok", 32'(bus.fail_pulse), 32'd0);
      for (int k = 1; k <= int'(UNLOCK_CYCLES); k++) begin
        check_eq("unlock_win", 32'(bus.unlock), 32'd1);
        check_eq("ready_win", 32'(bus.digit_ready), 32'd0);
        if (k == prog_at) begin
          bus.prog_req  = 1'b1;
          bus.prog_code = nc;
          step();
          bus.prog_req  = 1'b0;
          check_eq("prog_ack", 32'(bus.prog_ack), 32'd1);
          check_eq("unlock_prog_end", 32'(bus.unlock), 32'd0);
          model_code = nc;
          step();
          check_eq("prog_ack_pulse", 32'(bus.prog_ack), 32'd0);
          return;
        end
        step();
      end
      check_eq("unlock_end", 32'(bus.unlock), 32'd0);
      check_eq("ready_end", 32'(bus.digit_ready), 32'd1);
    end else begin
      model_fails++;
      check_eq("fail_pulse", 32'(bus.fail_pulse), 32'd1);
      check_eq("fail_count", 32'(bus.fail_count), 32'(model_fails));
      check_eq("unlock_bad", 32'(bus.unlock), 32'd0);
      if (model_fails == int'(MAX_FAILS)) begin
        for (int k = 1; k <= int'(LOCKOUT_CYCLES); k++) begin
          check_eq("locked_out", 32'(bus.locked_out), 32'd1);
          check_eq("ready_lock", 32'(bus.digit_ready), 32'd0);
          check_eq("prog_ack_lock", 32'(bus.prog_ack), 32'd0);
          if (k == 2) check_eq("fail_pulse_once", 32'(bus.fail_pulse), 32'd0);
          bus.digit_valid = (k < int'(LOCKOUT_CYCLES)) ? 1'($urandom_range(0, 1)) : 1'b0;
          bus.digit       = 3'($urandom);
          bus.prog_req    = (k < int'(LOCKOUT_CYCLES)) ? 1'b1 : 1'b0;
          bus.prog_code   = 9'($urandom);
          step();
        end
        bus.digit_valid = 1'b0;
        bus.prog_req    = 1'b0;
        model_fails     = 0;
        check_eq("lock_exit", 32'(bus.locked_out), 32'd0);
        check_eq("lock_exit_count", 32'(bus.fail_count), 32'd0);
        check_eq("lock_exit_ready", 32'(bus.digit_ready), 32'd1);
        check_eq("lock_exit_ack", 32'(bus.prog_ack), 32'd0);
      end else begin
        step();
        check_eq("fail_pulse_once", 32'(bus.fail_pulse), 32'd0);
        check_eq("ready_after_fail", 32'(bus.digit_ready), 32'd1);
      end
    end
  endtask

  task automatic check_all_low(input string tag);
    check_eq({tag, "_unlock"}, 32'(bus.unlock), 32'd0);
    check_eq({tag, "_locked"}, 32'(bus.locked_out), 32'd0);
    check_eq({tag, "_fail_pulse"}, 32'(bus.fail_pulse), 32'd0);
    check_eq({tag, "_prog_ack"}, 32'(bus.prog_ack), 32'd0);
    check_eq({tag, "_fail_count"}, 32'(bus.fail_count), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] rc;
    logic [8:0] rnc;
    int         pa;

    bus.digit_valid = 1'b0;
    bus.digit       = '0;
    bus.prog_req    = 1'b0;
    bus.prog_code   = '0;
    model_code      = DEFAULT_CODE;
    model_fails     = 0;

    #1;
    check_all_low("reset");
    repeat (3) step();
    reset = 1'b1;
    step();
    check_eq("ready_after_reset", 32'(bus.digit_ready), 32'd1);

    // Default code on consecutive cycles
    send_code(DEFAULT_CODE, 0);
    check_result(DEFAULT_CODE, 0, '0);

    // Three wrong attempts trigger lockout; prog_req during lockout is ignored
    repeat (3) begin
      send_code(WRONG_CODE, 0);
      check_result(WRONG_CODE, 0, '0);
    end

    // Code unchanged by prog_req while idle/locked
    idle_gap(4);
    send_code(DEFAULT_CODE, 1);
    check_result(DEFAULT_CODE, 0, '0);

    // Reprogram in window cycle 3, old code fails, new code unlocks
    send_code(DEFAULT_CODE, 1);
    check_result(DEFAULT_CODE, 3, NEW_CODE);
    send_code(DEFAULT_CODE, 1);
    check_result(DEFAULT_CODE, 0, '0);
    send_code(NEW_CODE, 1);
    check_result(NEW_CODE, 0, '0);

    // Reset mid-entry with a non-zero fail count and a reprogrammed code
    send_code(WRONG_CODE, 0);
    check_result(WRONG_CODE, 0, '0);
    send_digit(DEFAULT_CODE[8:6]);
    send_digit(DEFAULT_CODE[5:3]);
    reset = 1'b0;
    #1;
    check_all_low("rst_entry");
    model_code  = DEFAULT_CODE;
    model_fails = 0;
    step();
    reset = 1'b1;
    step();
    send_code(DEFAULT_CODE, 0);
    check_result(DEFAULT_CODE, 0, '0);

    // Reset mid-unlock
    send_code(DEFAULT_CODE, 0);
    repeat (3) step();
    check_eq("unlock_pre_rst", 32'(bus.unlock), 32'd1);
    reset = 1'b0;
    #1;
    check_all_low("rst_unlock");
    step();
    reset = 1'b1;
    step();
    check_eq("ready_post_rst", 32'(bus.digit_ready), 32'd1);
    check_eq("unlock_post_rst", 32'(bus.unlock), 32'd0);

`ifdef LOCK_SEQ_ENTRY_TIMEOUT_EN
    send_digit(3'b011);
    repeat (TIMEOUT_CYCLES - 1) step();
    check_eq("tmo_not_yet", 32'(bus.fail_pulse), 32'd0);
    check_eq("tmo_ready", 32'(bus.digit_ready), 32'd1);
    step();
    model_fails++;
    check_eq("tmo_fail_pulse", 32'(bus.fail_pulse), 32'd1);
    check_eq("tmo_fail_count", 32'(bus.fail_count), 32'(model_fails));
    check_eq("tmo_idle_ready", 32'(bus.digit_ready), 32'd1);
    step();
    check_eq("tmo_pulse_once", 32'(bus.fail_pulse), 32'd0);
`else
    send_digit(3'b011);
    repeat (TIMEOUT_CYCLES + 8) step();
    check_eq("no_tmo_fail", 32'(bus.fail_pulse), 32'd0);
    check_eq("no_tmo_count", 32'(bus.fail_count), 32'd0);
    send_digit(3'b111);
    send_digit(3'b101);
    check_result(DEFAULT_CODE, 0, '0);
`endif

    // Randomized attempts: correct code, near-miss, or random code; occasional reprogram
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 2))
        0:       rc = model_code;
        1:       rc = model_code ^ (9'b111 << (3 * $urandom_range(0, 2)));
        default: rc = 9'($urandom);
      endcase
      pa  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, UNLOCK_CYCLES)) : 0;
      rnc = 9'($urandom);
      send_code(rc, 2);
      check_result(rc, pa, rnc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
